// File: rtl/periph_bus_bridge.sv
// periph_bus_bridge: decodes the FemtoRV32 data bus into N_SLAVES one-hot
// selects and registers each transaction. It supports per-slave wait states,
// CPU stall signals, and a bus timeout with sticky error capture.
// Slave 0 is the default (RAM) target for any address outside the peripheral pages.
module periph_bus_bridge #(
  parameter int unsigned N_SLAVES  = 7,
  parameter logic [15:0] BASE_PAGE = 16'h0040,
  parameter int unsigned TIMEOUT   = 255,
  parameter logic [31:0] ERR_DATA  = 32'h6666_6666
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [31:0]              cpu_addr,
  input  logic [31:0]              cpu_wdata,
  input  logic [3:0]               cpu_wmask,
  input  logic                     cpu_rstrb,
  output logic [31:0]              cpu_rdata,
  output logic                     cpu_rbusy,
  output logic                     cpu_wbusy,
  output logic [N_SLAVES-1:0]      s_cs,
  output logic                     s_rd,
  output logic                     s_wr,
  output logic [31:0]              s_addr,
  output logic [31:0]              s_wdata,
  output logic [3:0]               s_wmask,
  input  logic [32*N_SLAVES-1:0]   s_rdata,
  input  logic [N_SLAVES-1:0]      s_ready,
  input  logic                     err_clr,
  output logic                     err_flag,
  output logic [31:0]              err_addr
);

  // The counter only has to reach TIMEOUT-1.
  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_WAIT,
    S_DONE
  } state_t;

  state_t              state;
  logic                is_wr;
  logic [CW-1:0]       tcount;

  logic                wr_req;
  logic                rd_req;
  logic                in_xfer;
  logic                ready_hit;
  logic                expire;
  logic [16:0]         page_off;
  logic [N_SLAVES-1:0] cs_dec;
  logic [31:0]         rdata_mux;

  // A write takes priority over a read; a read is dropped if both are requested.
  assign wr_req  = |cpu_wmask;
  assign rd_req  = cpu_rstrb & ~wr_req;
  assign in_xfer = (state == S_ACCESS) || (state == S_WAIT);

  // The selected slave is already one-hot on s_cs, so ready is qualified by it.
  assign ready_hit = |(s_ready & s_cs);
  assign expire    = (TIMEOUT != 0) && (tcount == CW'(TIMEOUT - 1));

  // Stall the CPU from the request cycle until the DONE cycle.
  assign cpu_rbusy = ((state == S_IDLE) & rd_req) | (in_xfer & ~is_wr);
  assign cpu_wbusy = ((state == S_IDLE) & wr_req) | (in_xfer & is_wr);

  // Address decode: page offsets 0..N_SLAVES-2 map to slaves 1..N_SLAVES-1.
  // A page below BASE_PAGE wraps into bit 16 and never matches.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    page_off = {1'b0, cpu_addr[31:16]} - {1'b0, BASE_PAGE};
    cs_dec   = '0;
    for (int k = 1; k < int'(N_SLAVES); k++) begin
      cs_dec[k] = (page_off == 17'(k - 1));
    end
    cs_dec[0] = ~(|cs_dec);
  end

  // Read-data mux driven by the registered one-hot select.
  always_comb begin
    rdata_mux = '0;
    for (int k = 0; k < int'(N_SLAVES); k++) begin
      if (s_cs[k]) rdata_mux = rdata_mux | s_rdata[32*k +: 32];
    end
  end

  // Transaction FSM together with its registered strobes, read data and error capture.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= S_IDLE;
      is_wr     <= 1'b0;
      tcount    <= '0;
      cpu_rdata <= '0;
      s_cs      <= '0;
      s_rd      <= 1'b0;
      s_wr      <= 1'b0;
      s_addr    <= '0;
      s_wdata   <= '0;
      s_wmask   <= '0;
      err_flag  <= 1'b0;
      err_addr  <= '0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
      s_rd <= 1'b0;
      s_wr <= 1'b0;
      if (err_clr) begin
        err_flag <= 1'b0;
        err_addr <= '0;
      end

      case (state)
        S_IDLE: begin
          if (wr_req || rd_req) begin
            state   <= S_ACCESS;
            is_wr   <= wr_req;
            s_addr  <= cpu_addr;
            s_wdata <= cpu_wdata;
            s_wmask <= cpu_wmask;
            s_cs    <= cs_dec;
            s_rd    <= rd_req;
            s_wr    <= wr_req;
            tcount  <= '0;
          end
        end

        S_ACCESS, S_WAIT: begin
          tcount <= tcount + CW'(1);
          if (ready_hit) begin
            state <= S_DONE;
            s_cs  <= '0;
            if (!is_wr) cpu_rdata <= rdata_mux;
          end else if (expire) begin
            state    <= S_DONE;
            s_cs     <= '0;
            if (!is_wr) cpu_rdata <= ERR_DATA;
            // A timeout overrides a clear issued in the same cycle.
            err_flag <= 1'b1;
            if (!err_flag || err_clr) err_addr <= s_addr;
          end else begin
            state <= S_WAIT;
          end
        end

        S_DONE: state <= S_IDLE;

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_periph_bus_bridge.sv
// Testbench for periph_bus_bridge. A transaction-level model checks every
// cycle, and directed transactions use hand-computed expectations.
module tb_periph_bus_bridge;

  localparam int NS   = 7;
  localparam int BASE = 'h40;
  localparam int TMO  = 8;
  localparam logic [31:0] ERR = 32'h6666_6666;

  logic              clk = 1'b0;
  logic              resetn = 1'b1;
  logic [31:0]       cpu_addr = '0;
  logic [31:0]       cpu_wdata = '0;
  logic [3:0]        cpu_wmask = '0;
  logic              cpu_rstrb = 1'b0;
  logic [31:0]       cpu_rdata;
  logic              cpu_rbusy;
  logic              cpu_wbusy;
  logic [NS-1:0]     s_cs;
  logic              s_rd;
  logic              s_wr;
  logic [31:0]       s_addr;
  logic [31:0]       s_wdata;
  logic [3:0]        s_wmask;
  logic [32*NS-1:0]  s_rdata;
  logic [NS-1:0]     s_ready = '1;
  logic              err_clr = 1'b0;
  logic              err_flag;
  logic [31:0]       err_addr;

  logic [31:0]       rd_val [NS];

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NS; g++) begin : g_rdata
    assign s_rdata[32*g +: 32] = rd_val[g];
  end

  periph_bus_bridge #(
    .N_SLAVES (NS),
    .BASE_PAGE(16'h0040),
    .TIMEOUT  (TMO),
    .ERR_DATA (ERR)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .cpu_addr (cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_wmask(cpu_wmask),
    .cpu_rstrb(cpu_rstrb),
    .cpu_rdata(cpu_rdata),
    .cpu_rbusy(cpu_rbusy),
    .cpu_wbusy(cpu_wbusy),
    .s_cs     (s_cs),
    .s_rd     (s_rd),
    .s_wr     (s_wr),
    .s_addr   (s_addr),
    .s_wdata  (s_wdata),
    .s_wmask  (s_wmask),
    .s_rdata  (s_rdata),
    .s_ready  (s_ready),
    .err_clr  (err_clr),
    .err_flag (err_flag),
    .err_addr (err_addr)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_active = 0;   // a transaction is between its request and its completion
  bit          m_done   = 0;   // completion cycle: no request is accepted
  int          m_age    = 0;   // number of in-flight cycles already elapsed
  int          m_sel    = 0;
  bit          m_wr     = 0;
  logic [31:0] m_addr = '0, m_wdata = '0, m_rdata = '0, m_err_addr = '0;
  logic [3:0]  m_wmask = '0;
  bit          m_err = 0;

  function automatic int decode(input logic [31:0] a);
    int page;
    page = int'(a[31:16]);
    if (page >= BASE && page <= BASE + NS - 2) return page - BASE + 1;
    return 0;
  endfunction

  task automatic model_step();
    bit fin, to, old_err;
    if (!resetn) begin
      m_active = 0; m_done = 0; m_age = 0; m_sel = 0; m_wr = 0;
      m_addr = '0; m_wdata = '0; m_wmask = '0; m_rdata = '0;
      m_err = 0; m_err_addr = '0;
      return;
    end
    fin = 0; to = 0; old_err = m_err;
    if (m_active) begin
      if (s_ready[m_sel]) begin
        fin = 1;
        if (!m_wr) m_rdata = rd_val[m_sel];
      end else if (m_age + 1 == TMO) begin
        fin = 1; to = 1;
        if (!m_wr) m_rdata = ERR;
      end
      m_age++;
    end
    if (to) begin
      m_err = 1;
      if (!old_err || err_clr) m_err_addr = m_addr;
    end else if (err_clr) begin
      m_err = 0; m_err_addr = '0;
    end
    if (m_active) begin
      if (fin) begin m_active = 0; m_done = 1; end
    end else if (m_done) begin
      m_done = 0;
    end else if ((|cpu_wmask) || cpu_rstrb) begin
      m_active = 1; m_age = 0;
      m_wr    = |cpu_wmask;
      m_sel   = decode(cpu_addr);
      m_addr  = cpu_addr;
      m_wdata = cpu_wdata;
      m_wmask = cpu_wmask;
    end
  endtask

  initial forever begin
    @(posedge clk or negedge resetn);
    model_step();
  end

  // Compare process: checks all outputs against the model on every falling edge.
  initial forever begin
    logic [NS-1:0] e_cs;
    bit idle_req;
    @(negedge clk);
    if (cmp_en) begin
      e_cs = '0;
      if (m_active) e_cs[m_sel] = 1'b1;
      idle_req = !m_active && !m_done;
      check("s_cs",      32'(s_cs),      32'(e_cs));
      check("s_rd",      32'(s_rd),      32'(m_active && m_age == 0 && !m_wr));
      check("s_wr",      32'(s_wr),      32'(m_active && m_age == 0 && m_wr));
      check("cpu_rbusy", 32'(cpu_rbusy), 32'((m_active && !m_wr) || (idle_req && cpu_rstrb && cpu_wmask == 0)));
      check("cpu_wbusy", 32'(cpu_wbusy), 32'((m_active && m_wr) || (idle_req && cpu_wmask != 0)));
      check("cpu_rdata", cpu_rdata, m_rdata);
      check("s_addr",    s_addr,    m_addr);
      check("s_wdata",   s_wdata,   m_wdata);
      check("s_wmask",   32'(s_wmask), 32'(m_wmask));
      check("err_flag",  32'(err_flag), 32'(m_err));
      check("err_addr",  err_addr,  m_err_addr);
    end
  end

  // ---------------- stimulus ----------------
  // Called at posedge+1 in an idle cycle. The selected slave asserts ready
  // `delay` cycles after ACCESS and then presents ready_data.
  // Returns the number of busy cycles and the s_cs value seen in ACCESS.
  task automatic run_txn(input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wmask, input logic rstrb,
                         input int sel, input int delay, input logic [31:0] ready_data,
                         output int busy_cyc, output logic [NS-1:0] cs_acc);
    busy_cyc = 0;
    cs_acc   = '0;
    s_ready  = '1;
    if (delay > 0) s_ready[sel] = 1'b0;
    cpu_addr = addr; cpu_wdata = wdata; cpu_wmask = wmask; cpu_rstrb = rstrb;
    @(negedge clk);
    if (cpu_rbusy || cpu_wbusy) busy_cyc++;
    @(posedge clk); #1;
    cpu_rstrb = 1'b0; cpu_wmask = '0;
    for (int k = 0; k < 40; k++) begin
      if (k == delay) begin
        s_ready[sel] = 1'b1;
        rd_val[sel]  = ready_data;
      end
      @(negedge clk);
      if (k == 0) cs_acc = s_cs;
      if (!(cpu_rbusy || cpu_wbusy)) break;
      busy_cyc++;
      @(posedge clk); #1;
    end
    s_ready = '1;
    @(posedge clk); #1;
  endtask

  initial begin
    int busy;
    logic [NS-1:0] cs;
    for (int k = 0; k < NS; k++) rd_val[k] = 32'hA000_0000 + 32'(k);
    rd_val[0] = 32'h1234_5678;

    // Assert reset away from a clock edge.
    #2 resetn = 1'b0;
    #1 cmp_en = 1'b1;
    check("rst cpu_rdata", cpu_rdata, 32'h0);
    check("rst s_cs", 32'(s_cs), 32'h0);
    check("rst err_flag", 32'(err_flag), 32'h0);
    repeat (3) @(posedge clk);
    #2 resetn = 1'b1;
    @(posedge clk); #1;

    // 1: zero-wait read from slave 0.
    run_txn(32'h0000_0100, 32'h0, 4'h0, 1'b1, 0, 0, 32'h1234_5678, busy, cs);
    check("t1 busy", 32'(busy), 32'd2);
    check("t1 cs", 32'(cs), 32'h01);
    check("t1 rdata", cpu_rdata, 32'h1234_5678);

    // 2: write to slave 1; the read data must be unchanged.
    run_txn(32'h0040_0004, 32'h41, 4'hF, 1'b0, 1, 0, rd_val[1], busy, cs);
    check("t2 busy", 32'(busy), 32'd2);
    check("t2 cs", 32'(cs), 32'h02);
    check("t2 s_addr", s_addr, 32'h0040_0004);
    check("t2 s_wdata", s_wdata, 32'h41);
    check("t2 rdata", cpu_rdata, 32'h1234_5678);

    // 3: read from slave 3 with five wait cycles; data is sampled at the ready edge.
    rd_val[3] = 32'hDEAD_0003;
    run_txn(32'h0042_0000, 32'h0, 4'h0, 1'b1, 3, 5, 32'hC0DE_0003, busy, cs);
    check("t3 busy", 32'(busy), 32'd7);
    check("t3 rdata", cpu_rdata, 32'hC0DE_0003);

    // 4: read times out on slave 2.
    run_txn(32'h0041_0000, 32'h0, 4'h0, 1'b1, 2, 100, rd_val[2], busy, cs);
    check("t4 busy", 32'(busy), 32'd9);
    check("t4 rdata", cpu_rdata, ERR);
    check("t4 err_flag", 32'(err_flag), 32'h1);
    check("t4 err_addr", err_addr, 32'h0041_0000);

    // 4b: a second timeout (a write) keeps the first error address and leaves cpu_rdata unchanged.
    run_txn(32'h0042_0008, 32'h55, 4'h3, 1'b0, 3, 100, rd_val[3], busy, cs);
    check("t4b busy", 32'(busy), 32'd9);
    check("t4b err_addr", err_addr, 32'h0041_0000);
    check("t4b rdata", cpu_rdata, ERR);

    // 4c: err_clr clears the flag and the address.
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    check("t4c err_flag", 32'(err_flag), 32'h0);
    check("t4c err_addr", err_addr, 32'h0);

    // 5: out-of-range pages route to slave 0; the last page routes to slave 6.
    run_txn(32'h0047_0000, 32'h0, 4'h0, 1'b1, 0, 0, 32'h1234_5678, busy, cs);
    check("t5 cs 0x47", 32'(cs), 32'h01);
    run_txn(32'h0045_0010, 32'h0, 4'h0, 1'b1, 6, 0, 32'h6666_0006, busy, cs);
    check("t5 cs 0x45", 32'(cs), 32'h40);
    check("t5 rdata 0x45", cpu_rdata, 32'h6666_0006);
    run_txn(32'h003F_0000, 32'h0, 4'h0, 1'b1, 0, 0, 32'h1234_5678, busy, cs);
    check("t5 cs 0x3F", 32'(cs), 32'h01);

    // Ready arriving in the expiry cycle completes normally.
    run_txn(32'h0043_0000, 32'h0, 4'h0, 1'b1, 4, TMO - 1, 32'hBEEF_0004, busy, cs);
    check("edge busy", 32'(busy), 32'd9);
    check("edge rdata", cpu_rdata, 32'hBEEF_0004);
    check("edge err_flag", 32'(err_flag), 32'h0);

    // When both are requested, the write wins and the read is dropped.
    run_txn(32'h0044_0000, 32'h77, 4'h3, 1'b1, 5, 0, rd_val[5], busy, cs);
    check("ww cs", 32'(cs), 32'h20);
    check("ww rdata", cpu_rdata, 32'hBEEF_0004);
    check("ww s_wmask", 32'(s_wmask), 32'h3);

    // 6: reset asserted during WAIT clears every output asynchronously.
    s_ready = '1; s_ready[3] = 1'b0;
    cpu_addr = 32'h0042_0000; cpu_rstrb = 1'b1;
    @(posedge clk); #1; cpu_rstrb = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    resetn = 1'b0;
    #1;
    check("t6 cpu_rdata", cpu_rdata, 32'h0);
    check("t6 s_cs", 32'(s_cs), 32'h0);
    check("t6 s_rd", 32'(s_rd), 32'h0);
    check("t6 s_wr", 32'(s_wr), 32'h0);
    check("t6 s_addr", s_addr, 32'h0);
    check("t6 s_wdata", s_wdata, 32'h0);
    check("t6 s_wmask", 32'(s_wmask), 32'h0);
    check("t6 rbusy", 32'(cpu_rbusy), 32'h0);
    check("t6 err_addr", err_addr, 32'h0);
    s_ready = '1;
    @(posedge clk); #2;
    resetn = 1'b1;
    @(posedge clk); #1;
    run_txn(32'h0040_0000, 32'h0, 4'h0, 1'b1, 1, 0, 32'h0101_0101, busy, cs);
    check("t6 busy", 32'(busy), 32'd2);
    check("t6 rdata", cpu_rdata, 32'h0101_0101);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
